// File: rtl/jtkicker_dwnld_remap_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jtkicker_dwnld_remap_if : SDRAM write-request channel (request + ack)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface jtkicker_dwnld_remap_if #(
    parameter int AW = 22
);
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [1:0]    prog_mask;
    logic          prog_we;
    logic          sdram_ack;

    modport master (
        output prog_addr, prog_data, prog_mask, prog_we,
        input  sdram_ack
    );

    modport slave (
        input  prog_addr, prog_data, prog_mask, prog_we,
        output sdram_ack
    );
endinterface
`default_nettype wire

// File: rtl/jtkicker_dwnld_remap.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jtkicker_dwnld_remap : ROM download address swizzle, SDRAM/PROM router
//                        with one-entry skid buffer. Optional checksum
//                        enabled by macro JTKICKER_DWNLD_CHK_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module jtkicker_dwnld_remap #(
    parameter int          AW         = 22,
    parameter logic [24:0] R1_START   = 25'h1FFFFFF,
    parameter logic [24:0] R2_START   = 25'h1FFFFFF,
    parameter logic [24:0] R3_START   = 25'h1FFFFFF,
    parameter logic [24:0] PROM_START = 25'h1FFFFFF,
    parameter logic [1:0]  MODE0      = 2'd0,
    parameter logic [1:0]  MODE1      = 2'd0,
    parameter logic [1:0]  MODE2      = 2'd0,
    parameter logic [1:0]  MODE3      = 2'd0
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    downloading,
    input  wire [24:0]             ioctl_addr,
    input  wire [7:0]              ioctl_dout,
    input  wire                    ioctl_wr,
    jtkicker_dwnld_remap_if.master sdram,
    output logic                   prom_we,
    output logic [10:0]            prom_addr,
    output logic [1:0]             region,
    output logic                   busy,
    output logic                   overrun,
    output logic [7:0]             chk,
    output logic                   chk_valid
);

    function automatic logic [24:0] swizzle(input logic [24:0] a, input logic [1:0] mode);
        logic [24:0] b;
        b = a;
        case (mode)
            2'd1: begin
                b[0]   = ~a[3];
                b[3:1] = a[2:0];
            end
            2'd2: begin
                b[0]   = ~a[3];
                b[1]   = ~a[4];
                b[5:2] = {a[5], a[2:0]};
            end
            2'd3:    b[0] = ~a[0];
            default: b = a;
        endcase
        return b;
    endfunction

    // Decoded form of the incoming byte
    logic [1:0]    in_region;
    logic [1:0]    in_mode;
    logic [24:0]   in_best;
    logic [24:0]   in_b;
    logic [24:0]   in_off;
    logic          in_prom;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_mask;
    logic [10:0]   in_prom_addr;

    always_comb begin
        in_region = 2'd0;
        in_best   = 25'd0;
        if (ioctl_addr >= R1_START && R1_START >= in_best) begin
            in_region = 2'd1;
            in_best   = R1_START;
        end
        if (ioctl_addr >= R2_START && R2_START >= in_best) begin
            in_region = 2'd2;
            in_best   = R2_START;
        end
        if (ioctl_addr >= R3_START && R3_START >= in_best) begin
            in_region = 2'd3;
            in_best   = R3_START;
        end
        case (in_region)
            2'd1:    in_mode = MODE1;
            2'd2:    in_mode = MODE2;
            2'd3:    in_mode = MODE3;
            default: in_mode = MODE0;
        endcase
        in_b         = swizzle(ioctl_addr, in_mode);
        in_addr      = AW'(in_b >> 1);
        in_mask      = in_b[0] ? 2'b01 : 2'b10;
        in_prom      = ioctl_addr >= PROM_START;
        in_off       = ioctl_addr - PROM_START;
        in_prom_addr = 11'(in_off);
    end

    logic          prog_we_q,   prog_we_d;
    logic [AW-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]    prog_data_q, prog_data_d;
    logic [1:0]    prog_mask_q, prog_mask_d;
    logic [1:0]    region_q,    region_d;
    logic          prom_we_q,   prom_we_d;
    logic [10:0]   prom_addr_q, prom_addr_d;
    logic          overrun_q,   overrun_d;
    logic          skid_full_q, skid_full_d;
    logic          skid_prom_q, skid_prom_d;
    logic [AW-1:0] skid_addr_q, skid_addr_d;
    logic [7:0]    skid_data_q, skid_data_d;
    logic [1:0]    skid_mask_q, skid_mask_d;
    logic [1:0]    skid_region_q, skid_region_d;
    logic [10:0]   skid_paddr_q,  skid_paddr_d;

    logic w_in, w_free, w_load, w_to_skid, w_drop, w_accept;

    // The output stage can take a new entry when idle or being acked this cycle;
    // the skid entry is older than any incoming byte so it always goes first.
    always_comb begin
        w_in      = downloading & ioctl_wr;
        w_free    = ~prog_we_q | sdram.sdram_ack;
        w_load    = w_free & (skid_full_q | w_in);
        w_to_skid = w_in & (w_free ? skid_full_q : ~skid_full_q);
        w_drop    = w_in & ~w_free & skid_full_q;
        w_accept  = w_in & ~w_drop;

        prog_we_d     = prog_we_q & ~w_free;
        prog_addr_d   = prog_addr_q;
        prog_data_d   = prog_data_q;
        prog_mask_d   = prog_mask_q;
        region_d      = region_q;
        prom_we_d     = 1'b0;
        prom_addr_d   = prom_addr_q;
        overrun_d     = overrun_q | w_drop;
        skid_full_d   = w_to_skid | (skid_full_q & ~w_free);
        skid_prom_d   = skid_prom_q;
        skid_addr_d   = skid_addr_q;
        skid_data_d   = skid_data_q;
        skid_mask_d   = skid_mask_q;
        skid_region_d = skid_region_q;
        skid_paddr_d  = skid_paddr_q;

        if (w_load) begin
            if (skid_full_q ? skid_prom_q : in_prom) begin
                prom_we_d   = 1'b1;
                prom_addr_d = skid_full_q ? skid_paddr_q : in_prom_addr;
                prog_data_d = skid_full_q ? skid_data_q  : ioctl_dout;
            end else begin
                prog_we_d   = 1'b1;
                prog_addr_d = skid_full_q ? skid_addr_q   : in_addr;
                prog_data_d = skid_full_q ? skid_data_q   : ioctl_dout;
                prog_mask_d = skid_full_q ? skid_mask_q   : in_mask;
                region_d    = skid_full_q ? skid_region_q : in_region;
            end
        end
        if (w_to_skid) begin
            skid_prom_d   = in_prom;
            skid_addr_d   = in_addr;
            skid_data_d   = ioctl_dout;
            skid_mask_d   = in_mask;
            skid_region_d = in_region;
            skid_paddr_d  = in_prom_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_we_q     <= 1'b0;
            prog_addr_q   <= '0;
            prog_data_q   <= 8'd0;
            prog_mask_q   <= 2'b11;
            region_q      <= 2'd0;
            prom_we_q     <= 1'b0;
            prom_addr_q   <= 11'd0;
            overrun_q     <= 1'b0;
            skid_full_q   <= 1'b0;
            skid_prom_q   <= 1'b0;
            skid_addr_q   <= '0;
            skid_data_q   <= 8'd0;
            skid_mask_q   <= 2'b11;
            skid_region_q <= 2'd0;
            skid_paddr_q  <= 11'd0;
        end else begin
            prog_we_q     <= prog_we_d;
            prog_addr_q   <= prog_addr_d;
            prog_data_q   <= prog_data_d;
            prog_mask_q   <= prog_mask_d;
            region_q      <= region_d;
            prom_we_q     <= prom_we_d;
            prom_addr_q   <= prom_addr_d;
            overrun_q     <= overrun_d;
            skid_full_q   <= skid_full_d;
            skid_prom_q   <= skid_prom_d;
            skid_addr_q   <= skid_addr_d;
            skid_data_q   <= skid_data_d;
            skid_mask_q   <= skid_mask_d;
            skid_region_q <= skid_region_d;
            skid_paddr_q  <= skid_paddr_d;
        end
    end

    assign sdram.prog_we   = prog_we_q;
    assign sdram.prog_addr = prog_addr_q;
    assign sdram.prog_data = prog_data_q;
    assign sdram.prog_mask = prog_mask_q;
    assign prom_we         = prom_we_q;
    assign prom_addr       = prom_addr_q;
    assign region          = region_q;
    assign overrun         = overrun_q;
    assign busy            = prog_we_q | skid_full_q;

`ifdef JTKICKER_DWNLD_CHK_EN
    logic       dl_q,        dl_d;
    logic       active_q,    active_d;
    logic [7:0] chk_q,       chk_d;
    logic       chk_valid_q, chk_valid_d;
    logic       w_rise;

    // active_q marks a download whose checksum has not yet been published
    always_comb begin
        w_rise      = downloading & ~dl_q;
        dl_d        = downloading;
        chk_d       = chk_q;
        active_d    = active_q | downloading;
        chk_valid_d = chk_valid_q;
        if (w_rise) begin
            chk_d       = w_accept ? ioctl_dout : 8'd0;
            chk_valid_d = 1'b0;
        end else if (w_accept) begin
            chk_d = chk_q + ioctl_dout;
        end
        if (!w_rise && active_q && !downloading && !busy) begin
            chk_valid_d = 1'b1;
            active_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q        <= 1'b0;
            active_q    <= 1'b0;
            chk_q       <= 8'd0;
            chk_valid_q <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            active_q    <= active_d;
            chk_q       <= chk_d;
            chk_valid_q <= chk_valid_d;
        end
    end

    assign chk       = chk_q;
    assign chk_valid = chk_valid_q;
`else
    assign chk       = 8'd0;
    assign chk_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtkicker_dwnld_remap.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jtkicker_dwnld_remap : directed self-checking bench for the download remapper
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_jtkicker_dwnld_remap;

    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        prom_we;
    logic [10:0] prom_addr;
    logic [1:0]  region;
    logic        busy;
    logic        overrun;
    logic [7:0]  chk;
    logic        chk_valid;

    int n_checks = 0;
    int n_errors = 0;

    jtkicker_dwnld_remap_if #(.AW(22)) sdram_if ();

    jtkicker_dwnld_remap #(
        .AW(22), .R1_START(25'h08000), .R2_START(25'h10000), .R3_START(25'h1FFFFFF),
        .PROM_START(25'h18000), .MODE0(2'd3), .MODE1(2'd1), .MODE2(2'd2), .MODE3(2'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .sdram(sdram_if), .prom_we(prom_we), .prom_addr(prom_addr),
        .region(region), .busy(busy), .overrun(overrun),
        .chk(chk), .chk_valid(chk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one byte strobe; returns at the negedge one cycle after the strobe.
    task automatic pulse_wr(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        sdram_if.sdram_ack = 1'b1;
        @(negedge clk);
        sdram_if.sdram_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; downloading = 1'b1; ioctl_addr = '0; ioctl_dout = '0;
        ioctl_wr = 1'b0; sdram_if.sdram_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sdram_if.prog_we, prom_we, busy, overrun, chk_valid, region, sdram_if.prog_mask,
             sdram_if.prog_addr, sdram_if.prog_data, prom_addr, chk} !==
            {5'b0, 2'd0, 2'b11, 22'd0, 8'd0, 11'd0, 8'd0}) begin
            n_errors++;
            $display("FAIL reset_state: got we=%b pw=%b busy=%b ovr=%b cv=%b reg=%0d mask=%b addr=%h data=%h paddr=%h chk=%h, expected mask=11 all else 0",
                     sdram_if.prog_we, prom_we, busy, overrun, chk_valid, region, sdram_if.prog_mask,
                     sdram_if.prog_addr, sdram_if.prog_data, prom_addr, chk);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_modes();
        // MODE3 byte-lane swap in region 0
        pulse_wr(25'h00004, 8'h11);
        n_checks++;
        if ({sdram_if.prog_we, region, sdram_if.prog_addr, sdram_if.prog_mask} !== {1'b1, 2'd0, 22'h000002, 2'b01}) begin
            n_errors++;
            $display("FAIL mode3: got we=%b reg=%0d addr=%h mask=%b expected we=1 reg=0 addr=000002 mask=01",
                     sdram_if.prog_we, region, sdram_if.prog_addr, sdram_if.prog_mask);
        end
        do_ack();
        n_checks++;
        if (sdram_if.prog_we !== 1'b0) begin
            n_errors++;
            $display("FAIL we_drop_after_ack: got %b expected 0", sdram_if.prog_we);
        end
        // MODE1 tile swizzle: 0x8003 -> b=0x8007
        pulse_wr(25'h08003, 8'h22);
        n_checks++;
        if ({sdram_if.prog_we, region, sdram_if.prog_addr, sdram_if.prog_mask, sdram_if.prog_data} !==
            {1'b1, 2'd1, 22'h004003, 2'b01, 8'h22}) begin
            n_errors++;
            $display("FAIL mode1: got we=%b reg=%0d addr=%h mask=%b data=%h expected we=1 reg=1 addr=004003 mask=01 data=22",
                     sdram_if.prog_we, region, sdram_if.prog_addr, sdram_if.prog_mask, sdram_if.prog_data);
        end
        do_ack();
        // MODE2 object swizzle: 0x10018 -> b=0x10000
        pulse_wr(25'h10018, 8'h33);
        n_checks++;
        if ({sdram_if.prog_we, region, sdram_if.prog_addr, sdram_if.prog_mask} !== {1'b1, 2'd2, 22'h008000, 2'b10}) begin
            n_errors++;
            $display("FAIL mode2_a: got we=%b reg=%0d addr=%h mask=%b expected we=1 reg=2 addr=008000 mask=10",
                     sdram_if.prog_we, region, sdram_if.prog_addr, sdram_if.prog_mask);
        end
        do_ack();
        // MODE2: 0x10025 -> b=0x10037
        pulse_wr(25'h10025, 8'h44);
        n_checks++;
        if ({sdram_if.prog_addr, sdram_if.prog_mask} !== {22'h00801B, 2'b01}) begin
            n_errors++;
            $display("FAIL mode2_b: got addr=%h mask=%b expected addr=00801b mask=01",
                     sdram_if.prog_addr, sdram_if.prog_mask);
        end
        do_ack();
    endtask

    task automatic test_prom();
        pulse_wr(25'h18005, 8'hA5);
        n_checks++;
        if ({prom_we, prom_addr, sdram_if.prog_data, sdram_if.prog_we} !== {1'b1, 11'd5, 8'hA5, 1'b0}) begin
            n_errors++;
            $display("FAIL prom_write: got pw=%b paddr=%h data=%h we=%b expected pw=1 paddr=005 data=a5 we=0",
                     prom_we, prom_addr, sdram_if.prog_data, sdram_if.prog_we);
        end
        @(negedge clk);
        n_checks++;
        if ({prom_we, sdram_if.prog_we} !== 2'b00) begin
            n_errors++;
            $display("FAIL prom_pulse_end: got pw=%b we=%b expected pw=0 we=0", prom_we, sdram_if.prog_we);
        end
    endtask

    task automatic test_idle_ignore();
        @(negedge clk);
        downloading = 1'b0;
        pulse_wr(25'h08000, 8'h77);
        n_checks++;
        if ({sdram_if.prog_we, prom_we, busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL ignore_idle: got we=%b pw=%b busy=%b expected 0 0 0", sdram_if.prog_we, prom_we, busy);
        end
        downloading = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        pulse_wr(25'h08000, 8'h01);
        pulse_wr(25'h08001, 8'h02);
        n_checks++;
        if ({sdram_if.prog_we, sdram_if.prog_addr, sdram_if.prog_data, busy, overrun} !==
            {1'b1, 22'h004000, 8'h01, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL skid_hold: got we=%b addr=%h data=%h busy=%b ovr=%b expected we=1 addr=004000 data=01 busy=1 ovr=0",
                     sdram_if.prog_we, sdram_if.prog_addr, sdram_if.prog_data, busy, overrun);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if ({sdram_if.prog_we, sdram_if.prog_addr, sdram_if.prog_data, sdram_if.prog_mask} !==
            {1'b1, 22'h004000, 8'h01, 2'b01}) begin
            n_errors++;
            $display("FAIL stable_no_ack: got we=%b addr=%h data=%h mask=%b expected we=1 addr=004000 data=01 mask=01",
                     sdram_if.prog_we, sdram_if.prog_addr, sdram_if.prog_data, sdram_if.prog_mask);
        end
        pulse_wr(25'h08002, 8'h03);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        do_ack();
        n_checks++;
        if ({sdram_if.prog_we, sdram_if.prog_addr, sdram_if.prog_data, sdram_if.prog_mask, busy} !==
            {1'b1, 22'h004001, 8'h02, 2'b01, 1'b1}) begin
            n_errors++;
            $display("FAIL skid_present: got we=%b addr=%h data=%h mask=%b busy=%b expected we=1 addr=004001 data=02 mask=01 busy=1",
                     sdram_if.prog_we, sdram_if.prog_addr, sdram_if.prog_data, sdram_if.prog_mask, busy);
        end
        do_ack();
        n_checks++;
        if ({sdram_if.prog_we, busy, overrun} !== 3'b001) begin
            n_errors++;
            $display("FAIL drain_sticky: got we=%b busy=%b ovr=%b expected we=0 busy=0 ovr=1",
                     sdram_if.prog_we, busy, overrun);
        end
    endtask

    task automatic test_ack_same_cycle();
        pulse_wr(25'h00004, 8'h11);
        @(negedge clk);
        sdram_if.sdram_ack = 1'b1;
        ioctl_addr = 25'h00006; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
        @(negedge clk);
        sdram_if.sdram_ack = 1'b0;
        ioctl_wr = 1'b0;
        n_checks++;
        if ({sdram_if.prog_we, sdram_if.prog_addr, sdram_if.prog_mask, sdram_if.prog_data} !==
            {1'b1, 22'h000003, 2'b01, 8'h22}) begin
            n_errors++;
            $display("FAIL ack_same_cycle: got we=%b addr=%h mask=%b data=%h expected we=1 addr=000003 mask=01 data=22",
                     sdram_if.prog_we, sdram_if.prog_addr, sdram_if.prog_mask, sdram_if.prog_data);
        end
        do_ack();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_same_cycle_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_checksum();
        @(negedge clk);
        downloading = 1'b0;
        @(negedge clk);
        downloading = 1'b1;
        sdram_if.sdram_ack = 1'b1;
        pulse_wr(25'h00010, 8'hFF);
        pulse_wr(25'h00011, 8'h02);
        pulse_wr(25'h18001, 8'h10);
        @(negedge clk);
        downloading = 1'b0;
        sdram_if.sdram_ack = 1'b0;
        repeat (3) @(negedge clk);
`ifdef JTKICKER_DWNLD_CHK_EN
        n_checks++;
        if ({chk, chk_valid} !== {8'h11, 1'b1}) begin
            n_errors++;
            $display("FAIL checksum: got chk=%h valid=%b expected chk=11 valid=1", chk, chk_valid);
        end
        downloading = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({chk, chk_valid} !== {8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL checksum_clear: got chk=%h valid=%b expected chk=00 valid=0", chk, chk_valid);
        end
`else
        n_checks++;
        if ({chk, chk_valid} !== {8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL checksum_tied: got chk=%h valid=%b expected chk=00 valid=0", chk, chk_valid);
        end
        downloading = 1'b1;
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic test_reset_midwrite();
        pulse_wr(25'h08004, 8'h5A);
        n_checks++;
        if (sdram_if.prog_we !== 1'b1) begin
            n_errors++;
            $display("FAIL midwrite_pre: got we=%b expected 1", sdram_if.prog_we);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sdram_if.prog_we, prom_we, busy, overrun, chk_valid, region, sdram_if.prog_mask,
             sdram_if.prog_addr, sdram_if.prog_data, prom_addr, chk} !==
            {5'b0, 2'd0, 2'b11, 22'd0, 8'd0, 11'd0, 8'd0}) begin
            n_errors++;
            $display("FAIL async_reset: got we=%b pw=%b busy=%b ovr=%b cv=%b reg=%0d mask=%b addr=%h data=%h paddr=%h chk=%h, expected mask=11 all else 0",
                     sdram_if.prog_we, prom_we, busy, overrun, chk_valid, region, sdram_if.prog_mask,
                     sdram_if.prog_addr, sdram_if.prog_data, prom_addr, chk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sdram_if.prog_we, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL post_reset_idle: got we=%b busy=%b expected 0 0", sdram_if.prog_we, busy);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_prom();
        test_idle_ignore();
        test_back_to_back();
        test_ack_same_cycle();
        test_checksum();
        test_reset_midwrite();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
